// File: rtl/keypad_pkg.sv
// Shared keypad definitions: capture FSM states, the 4x4 key map and one-hot helpers.
// The scanner and display blocks import this package as well.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUALIFY = 2'd1,
      HELD    = 2'd2
   } key_state_t;

   // Indexed by {row_index, col_index}
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] onehot_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      case (v)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/key_map.sv
// Combinational row/column to hex key code translation.
// Inputs are expected one-hot; anything else maps as if bit 0 were set.
module key_map
   import keypad_pkg::*;
(
   input  logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] code
);

   assign code = KEY_MAP[{onehot_index(row), onehot_index(col)}];

endmodule

// File: rtl/key_capture.sv
// Debounced key capture: qualifies a row/column sample for MIN_ON_CYCLES
// consecutive cycles, then captures one code per press and shifts the digit pair.
module key_capture
   import keypad_pkg::*;
#(
   parameter int MIN_ON_CYCLES = 2
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] R_out,
   input  logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old,
   output logic       decode_error
);

   localparam logic [3:0] MIN_ON = 4'(MIN_ON_CYCLES);

   key_state_t state, state_next;
   logic [3:0] count, count_next;
   logic [3:0] row_lat, row_next;
   logic [3:0] col_lat, col_next;
   logic       capture;
   logic       err_next;
   logic [3:0] mapped_code;

   // The live sample always equals the latched one whenever a capture fires
   key_map u_key_map (
      .row  (R_out),
      .col  (col),
      .code (mapped_code)
   );

   always_comb begin
      state_next = state;
      count_next = count;
      row_next   = row_lat;
      col_next   = col_lat;
      capture    = 1'b0;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (R_out != 4'd0) begin
               if (is_onehot(R_out) && is_onehot(col)) begin
                  row_next   = R_out;
                  col_next   = col;
                  count_next = 4'd1;
                  if (MIN_ON <= 4'd1) begin
                     state_next = HELD;
                     capture    = 1'b1;
                  end else begin
                     state_next = QUALIFY;
                  end
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         QUALIFY: begin
            if ((R_out == row_lat) && (col == col_lat)) begin
               count_next = (count == 4'hF) ? count : count + 4'd1;
               if (count_next >= MIN_ON) begin
                  state_next = HELD;
                  capture    = 1'b1;
               end
            end else begin
               state_next = IDLE;
            end
         end
         // Further keys are ignored until the row goes quiet
         HELD: begin
            if (R_out == 4'd0) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         count        <= 4'd0;
         row_lat      <= 4'd0;
         col_lat      <= 4'd0;
         key_code     <= 4'd0;
         key_valid    <= 1'b0;
         digit_new    <= 4'd0;
         digit_old    <= 4'd0;
         decode_error <= 1'b0;
      end else begin
         state        <= state_next;
         count        <= count_next;
         row_lat      <= row_next;
         col_lat      <= col_next;
         key_valid    <= capture;
         decode_error <= err_next;
         if (capture) begin
            key_code  <= mapped_code;
            digit_old <= digit_new;
            digit_new <= mapped_code;
         end
      end
   end

endmodule
